layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Controller that time-multiplexes one serial neuron-layer datapath across NUM_LAYERS successive layers of a fully-connected network.
- Accepts one input vector over a valid/ready stream and stores it in a ping-pong activation buffer.
- For each layer it clears the accumulators, streams activations and weight addresses, captures the layer outputs and writes them back into the buffer.
- After the last layer it streams the result vector out over valid/ready. It sits between the host stream interface and the layer datapath plus weight memory.

Parameters:
- LAYER_SIZE, 3: neurons per layer; also the input vector length.
- BIT_SIZE, 8: width of one activation word.
- NUM_LAYERS, 2: number of layer passes per input vector; must be ≥ 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller accepts an input word.
- in_data  input  BIT_SIZE  input activation word.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts the result word.
- out_data  output  BIT_SIZE  result word.
- busy  output  1  high in every state except IDLE.
- dp_clr  output  1  clears the datapath accumulators.
- dp_acc  output  1  datapath accumulates dp_x times the addressed weight.
- dp_x  output  BIT_SIZE  serial activation to the datapath.
- w_addr  output  $clog2(NUM_LAYERS*LAYER_SIZE)  weight memory row, equal to layer*LAYER_SIZE + input index.
- dp_load  output  1  datapath captures neuron outputs into its output shifter.
- dp_shift  output  1  datapath advances its output shifter by one.
- dp_y  input  BIT_SIZE  head of the datapath output shifter, post-activation.

Behaviour:
Interface and reset:
- Reset is asynchronous and active-low.
- While rst_n=0, or when it is asserted mid-operation:
  - state is IDLE;
  - the layer and element counters are 0;
  - every output is 0, including dp_x, w_addr and out_data.
- Activation buffer contents are not reset and are don't-care.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
- in_valid is ignored whenever in_ready=0.
- out_valid, once raised, holds with out_data stable until the transfer.

States:
- IDLE: in_ready=0. Moves to LOAD in the next cycle if in_valid=1; otherwise stays. In IDLE in_valid is only sampled for this transition; no word is consumed.
- LOAD: in_ready=1. Each transfer writes buffer A[cnt] and increments cnt. The transfer at cnt=LAYER_SIZE-1 moves to CLEAR with cnt=0 and layer=0.
- CLEAR: 1 cycle with dp_clr=1. Moves to ACCUM.
- ACCUM: LAYER_SIZE cycles with dp_acc=1, dp_x=src[cnt] and w_addr=layer*LAYER_SIZE+cnt. Moves to STORE after cnt=LAYER_SIZE-1.
- STORE: 1 cycle with dp_load=1. Moves to DRAIN with cnt=0.
- DRAIN, layer<NUM_LAYERS-1: LAYER_SIZE cycles with dp_shift=1. Each cycle writes dst[cnt]=dp_y. After the last word the buffers swap roles, layer increments and the state moves to CLEAR.
- DRAIN, final layer: out_valid=1 and out_data=dp_y. dp_shift=out_valid&out_ready. cnt advances only on a transfer; out_ready=0 stalls indefinitely with no shift. The transfer at cnt=LAYER_SIZE-1 moves to IDLE, or to LOAD if in_valid=1 in that same cycle.

Buffers:
- Source buffer for layer 0 is A.
- Source and destination alternate each layer.
- A layer never reads and writes the same buffer.

Timing:
- Latency with out_ready held at 1: first out_valid occurs (NUM_LAYERS-1)*(2*LAYER_SIZE+2) + LAYER_SIZE + 2 cycles after the cycle of the last input transfer.
- Default parameters give 13 cycles.
- Whole-vector throughput: LAYER_SIZE + NUM_LAYERS*(2*LAYER_SIZE+2) cycles, plus the IDLE cycle when entering from IDLE.

Boundaries:
- LAYER_SIZE=1: ACCUM and DRAIN last 1 cycle each.
- NUM_LAYERS=1: the first DRAIN is the output DRAIN.
- w_addr never exceeds NUM_LAYERS*LAYER_SIZE-1.
- dp_clr, dp_acc, dp_load and dp_shift are mutually exclusive.
- in_ready and out_valid are never both 1.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with in_valid=0 for 10 cycles -> all outputs 0, busy=0, state IDLE throughout.
- Default parameters, datapath model with identity weights and pass-through activation:
  - stimulus: input vector {5,7,9}, out_ready=1;
  - required: w_addr sequence 0,1,2 then 3,4,5;
  - required: out_valid first high 13 cycles after the third input transfer;
  - required: out_data 5,7,9 on consecutive cycles;
  - required: busy falls the cycle after the last output.
- Input gaps: in_valid toggles 1,0,1,0,1 -> exactly 3 words captured, in the given order; CLEAR starts the cycle after the third transfer.
- Output back-pressure: out_ready low for 4 cycles at output index 1 -> out_valid stays 1, out_data stable, dp_shift=0 while stalled; the output sequence is unchanged.
- Back-to-back vectors: in_valid=1 during the final output transfer -> state goes directly to LOAD (no IDLE cycle); the second vector's result is correct.
- Mid-operation reset: pulse rst_n=0 during the second-layer ACCUM -> all outputs go to 0 immediately and the block returns to IDLE. A following vector {1,2,3} then produces correct output.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequencer that reuses one serial neuron-layer datapath for NUM_LAYERS passes,
// ping-ponging activations between two buffers and streaming the final layer out.
module layer_sequencer #(
  parameter int LAYER_SIZE = 3,
  parameter int BIT_SIZE   = 8,
  parameter int NUM_LAYERS = 2,
  localparam int AW = ($clog2(NUM_LAYERS * LAYER_SIZE) > 0) ? $clog2(NUM_LAYERS * LAYER_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                busy,
  output logic                dp_clr,
  output logic                dp_acc,
  output logic [BIT_SIZE-1:0] dp_x,
  output logic [AW-1:0]       w_addr,
  output logic                dp_load,
  output logic                dp_shift,
  input  logic [BIT_SIZE-1:0] dp_y
);

  localparam int CW = ($clog2(LAYER_SIZE) > 0) ? $clog2(LAYER_SIZE) : 1;
  localparam int LW = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(LAYER_SIZE - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    ACCUM,
    STORE,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] layer;
  logic [AW-1:0] addr;
  logic          src_b;

  logic [BIT_SIZE-1:0] buf_a [LAYER_SIZE];
  logic [BIT_SIZE-1:0] buf_b [LAYER_SIZE];

  logic final_layer;
  logic last_cnt;
  logic drain_mid;
  logic out_xfer;

  assign final_layer = (layer == LAST_LAYER);
  assign last_cnt    = (cnt == LAST_CNT);
  assign drain_mid   = (state == DRAIN) && !final_layer;
  assign out_xfer    = (state == DRAIN) && final_layer && out_ready;

  // w_addr runs as a flat counter: layers are visited in order, so it equals
  // layer*LAYER_SIZE + cnt throughout every ACCUM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      layer <= '0;
      addr  <= '0;
      src_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (in_valid) state <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            if (last_cnt) begin
              state <= CLEAR;
              cnt   <= '0;
              layer <= '0;
              addr  <= '0;
              src_b <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          state <= ACCUM;
          cnt   <= '0;
        end
        ACCUM: begin
          addr <= addr + 1'b1;
          if (last_cnt) begin
            state <= STORE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STORE: begin
          state <= DRAIN;
          cnt   <= '0;
        end
        DRAIN: begin
          if (!final_layer) begin
            if (last_cnt) begin
              state <= CLEAR;
              cnt   <= '0;
              layer <= layer + 1'b1;
              src_b <= ~src_b;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (out_ready) begin
            if (last_cnt) begin
              state <= in_valid ? LOAD : IDLE;
              cnt   <= '0;
              layer <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer A takes the input vector and the outputs of odd layers; B the outputs of even layers.
  logic                wr_a;
  logic                wr_b;
  logic [BIT_SIZE-1:0] wr_a_data;

  assign wr_a      = ((state == LOAD) && in_valid) || (drain_mid && src_b);
  assign wr_b      = drain_mid && !src_b;
  assign wr_a_data = (state == LOAD) ? in_data : dp_y;

  always_ff @(posedge clk) begin
    if (wr_a) buf_a[cnt] <= wr_a_data;
    if (wr_b) buf_b[cnt] <= dp_y;
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign dp_clr    = (state == CLEAR);
  assign dp_acc    = (state == ACCUM);
  assign dp_load   = (state == STORE);
  assign out_valid = (state == DRAIN) && final_layer;
  assign out_data  = out_valid ? dp_y : '0;
  assign dp_shift  = drain_mid || out_xfer;
  assign w_addr    = dp_acc ? addr : '0;
  assign dp_x      = dp_acc ? (src_b ? buf_b[cnt] : buf_a[cnt]) : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: identity-weight datapath model plus an output scoreboard.
module tb_layer_sequencer;

  localparam int L  = 3;
  localparam int B  = 8;
  localparam int N  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  out_data;
  logic          busy;
  logic          dp_clr;
  logic          dp_acc;
  logic [B-1:0]  dp_x;
  logic [AW-1:0] w_addr;
  logic          dp_load;
  logic          dp_shift;
  logic [B-1:0]  dp_y;

  int tests_run = 0;
  int failed    = 0;
  int out_count = 0;

  logic [B-1:0]  sb[$];
  logic [AW-1:0] addr_log[$];

  layer_sequencer #(.LAYER_SIZE(L), .BIT_SIZE(B), .NUM_LAYERS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dp_clr(dp_clr), .dp_acc(dp_acc), .dp_x(dp_x),
    .w_addr(w_addr), .dp_load(dp_load), .dp_shift(dp_shift), .dp_y(dp_y)
  );

  always #5 clk = ~clk;

  // Datapath model: identity weights (row i feeds neuron i), pass-through activation.
  logic [B-1:0] acc   [L];
  logic [B-1:0] shreg [L];

  always @(posedge clk) begin
    if (dp_clr) for (int i = 0; i < L; i++) acc[i] <= '0;
    if (dp_acc) acc[int'(w_addr) % L] <= acc[int'(w_addr) % L] + dp_x;
    if (dp_load) for (int i = 0; i < L; i++) shreg[i] <= acc[i];
    if (dp_shift) begin
      for (int i = 0; i < L - 1; i++) shreg[i] <= shreg[i + 1];
      shreg[L-1] <= '0;
    end
  end
  assign dp_y = shreg[0];

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (dp_acc) begin
      addr_log.push_back(w_addr);
      tests_run++;
      if (w_addr > AW'(N * L - 1)) begin
        failed++;
        $display("FAIL w_addr_range: got %0d, required <= %0d", w_addr, N * L - 1);
      end
    end
    tests_run++;
    if ((int'(dp_clr) + int'(dp_acc) + int'(dp_load) + int'(dp_shift)) > 1 || (in_ready && out_valid)) begin
      failed++;
      $display("FAIL exclusive: clr=%b acc=%b load=%b shift=%b in_ready=%b out_valid=%b, required at most one strobe and not both ready/valid",
               dp_clr, dp_acc, dp_load, dp_shift, in_ready, out_valid);
    end
    if (out_valid && out_ready) begin
      tests_run++;
      out_count++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL sb_underflow: got out_data=%0d with nothing expected", out_data);
      end else begin
        logic [B-1:0] exp_v;
        exp_v = sb.pop_front();
        $display("[TB] out %0d (expected %0d)", out_data, exp_v);
        if (out_data !== exp_v) begin
          failed++;
          $display("FAIL sb_out_data: got %0d, required %0d", out_data, exp_v);
        end
      end
    end
  end

  function automatic logic [25:0] all_outs();
    return {in_ready, out_valid, out_data, busy, dp_clr, dp_acc, dp_x, w_addr, dp_load, dp_shift};
  endfunction

  // Offers one word and returns #1 after the edge that transferred it.
  task automatic send_word(input logic [B-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 50);
    tests_run++;
    if (!in_ready) begin
      failed++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(d);
    $display("[TB] in  %0d", d);
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    tests_run++;
    if (busy || sb.size() != 0) begin
      failed++;
      $display("FAIL %s_idle: busy=%b pending=%0d, required busy=0 pending=0", name, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (all_outs() !== '0) begin
        failed++;
        $display("FAIL reset_hold: outputs=%h, required 0", all_outs());
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (all_outs() !== '0) begin
        failed++;
        $display("FAIL reset_idle: outputs=%h, required 0", all_outs());
      end
    end
  endtask

  task automatic test_basic();
    logic [B-1:0] v [3];
    int k = 0;
    v[0] = 8'd5; v[1] = 8'd7; v[2] = 8'd9;
    addr_log.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_word(v[i]);
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    tests_run++;
    if (k != 13) begin
      failed++;
      $display("FAIL basic_latency: got %0d cycles, required 13", k);
    end
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== v[j]) begin
        failed++;
        $display("FAIL basic_out%0d: got valid=%b data=%0d, required valid=1 data=%0d", j, out_valid, out_data, v[j]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL basic_busy_fall: got busy=%b, required 0", busy);
    end
    tests_run++;
    if (addr_log.size() != 6) begin
      failed++;
      $display("FAIL basic_addr_count: got %0d, required 6", addr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (addr_log[i] !== AW'(i)) begin
          failed++;
          $display("FAIL basic_w_addr%0d: got %0d, required %0d", i, addr_log[i], i);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int start_count = out_count;
    logic [B-1:0] v [3];
    v[0] = 8'd11; v[1] = 8'd22; v[2] = 8'd33;
    @(posedge clk); #1;
    send_word(v[0]);
    @(posedge clk); #1;
    send_word(v[1]);
    @(posedge clk); #1;
    send_word(v[2]);
    tests_run++;
    if (dp_clr !== 1'b1) begin
      failed++;
      $display("FAIL gaps_clear: got dp_clr=%b after third transfer, required 1", dp_clr);
    end
    wait_idle("gaps");
    tests_run++;
    if (out_count - start_count != 3) begin
      failed++;
      $display("FAIL gaps_count: got %0d outputs, required 3", out_count - start_count);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    @(posedge clk); #1;
    send_word(8'd40);
    send_word(8'd50);
    send_word(8'd60);
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'd50 || dp_shift !== 1'b0) begin
        failed++;
        $display("FAIL stall%0d: got valid=%b data=%0d shift=%b, required valid=1 data=50 shift=0",
                 i, out_valid, out_data, dp_shift);
      end
    end
    out_ready = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_back_to_back();
    int k = 0;
    @(posedge clk); #1;
    send_word(8'd3);
    send_word(8'd1);
    send_word(8'd4);
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'd15;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL b2b_direct_load: got in_ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    @(posedge clk); #1;
    sb.push_back(8'd15);
    $display("[TB] in  %0d", 15);
    send_word(8'd26);
    send_word(8'd37);
    wait_idle("b2b");
  endtask

  task automatic test_mid_reset();
    int k = 0;
    @(posedge clk); #1;
    send_word(8'd100);
    send_word(8'd120);
    send_word(8'd140);
    while (!(dp_acc && w_addr == 3'd4) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    tests_run++;
    if (!(dp_acc && w_addr == 3'd4)) begin
      failed++;
      $display("FAIL mid_reach_accum: got dp_acc=%b w_addr=%0d, required 1 and 4", dp_acc, w_addr);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (all_outs() !== '0) begin
      failed++;
      $display("FAIL mid_reset_outs: outputs=%h, required 0", all_outs());
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset_idle: got busy=%b, required 0", busy);
    end
    send_word(8'd1);
    send_word(8'd2);
    send_word(8'd3);
    wait_idle("mid_reset");
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
